// File: rtl/axi_sram_slave_if.sv
// AXI4 slave bus plus synchronous SRAM port bundle for axi_sram_slave.
// The slave modport is the bridge side; the master modport drives AXI and models the SRAM.
interface axi_sram_slave_if #(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]   ARID;
  logic [31:0]       ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  logic [ID_W-1:0]   AWID;
  logic [31:0]       AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic              CS;
  logic              OE;
  logic [3:0]        WEB;
  logic [ADDR_W-1:0] A;
  logic [31:0]       DI;
  logic [31:0]       DO;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    output CS, OE, WEB, A, DI,
    input  DO
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    input  CS, OE, WEB, A, DI,
    output DO
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging single-outstanding bursts onto a 32-bit synchronous SRAM.
// Define AXI_SRAM_RR_ARB_EN for round-robin read/write arbitration; default gives writes priority.
module axi_sram_slave #(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 4
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi_sram_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e            state_q, state_d;
  logic              run_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic              wlastErr_q, wlastErr_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              preferWr;
  logic              grantWr;
  logic              grantRd;
  logic              lastBeat;
  logic              wlastBad;
  logic [31:0]       addrNext;
  logic [31:0]       incr;
  logic [31:0]       wrapMask;

  function automatic logic burstBad(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [LEN_W-1:0] len);
    logic wrapLenOk;
    wrapLenOk = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                (len == LEN_W'(7)) || (len == LEN_W'(15));
    return (burst == 2'b11) || (size > 3'd2) || ((burst == 2'b10) && !wrapLenOk);
  endfunction

`ifdef AXI_SRAM_RR_ARB_EN
  logic wrLast_q, wrLast_d;

  // Pointer remembers which direction won last; the other side wins the next tie.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrLast_q <= 1'b0;
    end else begin
      wrLast_q <= wrLast_d;
    end
  end

  always_comb begin
    wrLast_d = wrLast_q;
    if (grantWr) begin
      wrLast_d = 1'b1;
    end else if (grantRd) begin
      wrLast_d = 1'b0;
    end
  end

  assign preferWr = ~wrLast_q;
`else
  assign preferWr = 1'b1;
`endif

  // Grants are held off until the cycle after reset release so nothing is accepted during reset.
  always_comb begin
    grantWr = 1'b0;
    grantRd = 1'b0;
    if ((state_q == IDLE) && run_q) begin
      if (bus.AWVALID && (!bus.ARVALID || preferWr)) begin
        grantWr = 1'b1;
      end else if (bus.ARVALID) begin
        grantRd = 1'b1;
      end
    end
  end

  assign lastBeat = (beat_q == len_q);
  assign wlastBad = (bus.WLAST != lastBeat);
  assign incr     = 32'd1 << size_q;
  assign wrapMask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;

  always_comb begin
    case (burst_q)
      2'b01:   addrNext = addr_q + incr;
      2'b10:   addrNext = (addr_q & ~wrapMask) | ((addr_q + incr) & wrapMask);
      default: addrNext = addr_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      wlastErr_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      wlastErr_q <= wlastErr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write beats hit the SRAM combinationally in the W handshake cycle; reads take an
  // address cycle, then a capture cycle before RVALID because DO lags CS by one clock.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    wlastErr_d  = wlastErr_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    bresp_d     = bresp_q;
    bus.CS      = 1'b0;
    bus.WEB     = 4'hF;
    bus.A       = '0;
    bus.DI      = '0;
    bus.WREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grantWr) begin
          id_d       = bus.AWID;
          addr_d     = bus.AWADDR;
          len_d      = bus.AWLEN;
          size_d     = bus.AWSIZE;
          burst_d    = bus.AWBURST;
          beat_d     = '0;
          err_d      = burstBad(bus.AWBURST, bus.AWSIZE, bus.AWLEN);
          wlastErr_d = 1'b0;
          state_d    = WR_DATA;
        end else if (grantRd) begin
          id_d       = bus.ARID;
          addr_d     = bus.ARADDR;
          len_d      = bus.ARLEN;
          size_d     = bus.ARSIZE;
          burst_d    = bus.ARBURST;
          beat_d     = '0;
          err_d      = burstBad(bus.ARBURST, bus.ARSIZE, bus.ARLEN);
          state_d    = RD_ADDR;
        end
      end

      RD_ADDR: begin
        bus.CS   = 1'b1;
        bus.A    = addr_q[ADDR_W+1:2];
        rvalid_d = 1'b0;
        state_d  = RD_DATA;
      end

      RD_DATA: begin
        if (!rvalid_q) begin
          rdata_d  = err_q ? 32'd0 : bus.DO;
          rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
          rlast_d  = lastBeat;
          rvalid_d = 1'b1;
        end else if (bus.RREADY) begin
          rvalid_d = 1'b0;
          if (lastBeat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            addr_d  = addrNext;
            state_d = RD_ADDR;
          end
        end
      end

      WR_DATA: begin
        bus.WREADY = 1'b1;
        if (bus.WVALID) begin
          if (!err_q) begin
            bus.CS  = 1'b1;
            bus.WEB = ~bus.WSTRB;
          end
          bus.A  = addr_q[ADDR_W+1:2];
          bus.DI = bus.WDATA;
          if (wlastBad) begin
            wlastErr_d = 1'b1;
          end
          if (lastBeat) begin
            bresp_d = (err_q || wlastErr_q || wlastBad) ? RESP_SLVERR : RESP_OKAY;
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + LEN_W'(1);
            addr_d = addrNext;
          end
        end
      end

      WR_RESP: begin
        if (bus.BREADY) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ARREADY = grantRd;
  assign bus.AWREADY = grantWr;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RID     = id_q;
  assign bus.BVALID  = (state_q == WR_RESP);
  assign bus.BRESP   = bresp_q;
  assign bus.BID     = id_q;
  assign bus.OE      = run_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed bursts feed expected queues that a monitor drains.
// Arbitration expectations follow AXI_SRAM_RR_ARB_EN when it is defined.
module tb_axi_sram_slave;
  localparam int ADDR_W = 14;
  localparam int ID_W   = 8;
  localparam int LEN_W  = 4;

  typedef struct {
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
    logic [ID_W-1:0] id;
  } rExp_t;

  typedef struct {
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } bExp_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_sram_slave_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int writeCount = 0;
  rExp_t rQueue[$];
  bExp_t bQueue[$];
  logic [ADDR_W-1:0] readLog[$];
  logic [31:0] mem [16384] = '{default: 32'd0};
  logic [31:0] wBuf [16];
  logic [31:0] rBuf [16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // SRAM model: read data appears on DO one clock after a read strobe.
  initial begin : sramModel
    forever begin
      @(posedge ACLK);
      if (bus.CS === 1'b1) begin
        if (bus.WEB == 4'hF) begin
          bus.DO <= mem[bus.A];
          readLog.push_back(bus.A);
        end else begin
          writeCount++;
          for (int b = 0; b < 4; b++) begin
            if (!bus.WEB[b]) mem[bus.A][8*b +: 8] <= bus.DI[8*b +: 8];
          end
        end
      end
    end
  end

  initial begin : monitor
    rExp_t r;
    bExp_t b;
    forever begin
      @(negedge ACLK);
      if (ARESETn && bus.RVALID && bus.RREADY) begin
        if (rQueue.size() == 0) begin
          checkOutput("rUnexpected", 32'(bus.RVALID), 32'd0);
        end else begin
          r = rQueue.pop_front();
          checkOutput("rData", bus.RDATA, r.data);
          checkOutput("rResp", 32'(bus.RRESP), 32'(r.resp));
          checkOutput("rLast", 32'(bus.RLAST), 32'(r.last));
          checkOutput("rId", 32'(bus.RID), 32'(r.id));
        end
      end
      if (ARESETn && bus.BVALID && bus.BREADY) begin
        if (bQueue.size() == 0) begin
          checkOutput("bUnexpected", 32'(bus.BVALID), 32'd0);
        end else begin
          b = bQueue.pop_front();
          checkOutput("bResp", 32'(bus.BRESP), 32'(b.resp));
          checkOutput("bId", 32'(bus.BID), 32'(b.id));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstArready", 32'(bus.ARREADY), 32'd0);
    checkOutput("rstAwready", 32'(bus.AWREADY), 32'd0);
    checkOutput("rstWready", 32'(bus.WREADY), 32'd0);
    checkOutput("rstRvalid", 32'(bus.RVALID), 32'd0);
    checkOutput("rstBvalid", 32'(bus.BVALID), 32'd0);
    checkOutput("rstRdata", bus.RDATA, 32'd0);
    checkOutput("rstRid", 32'(bus.RID), 32'd0);
    checkOutput("rstBid", 32'(bus.BID), 32'd0);
    checkOutput("rstRresp", 32'(bus.RRESP), 32'd0);
    checkOutput("rstBresp", 32'(bus.BRESP), 32'd0);
    checkOutput("rstRlast", 32'(bus.RLAST), 32'd0);
    checkOutput("rstCs", 32'(bus.CS), 32'd0);
    checkOutput("rstOe", 32'(bus.OE), 32'd0);
    checkOutput("rstWeb", 32'(bus.WEB), 32'hF);
    checkOutput("rstA", 32'(bus.A), 32'd0);
  endtask

  task automatic awHandshake(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [LEN_W-1:0] len, input logic [1:0] burst);
    int cnt;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'd2;
    bus.AWBURST = burst; bus.AWVALID = 1'b1;
    cnt = 0;
    @(negedge ACLK);
    while (!bus.AWREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
    if (!bus.AWREADY) checkOutput("awTimeout", 32'(bus.AWREADY), 32'd1);
    tick();
    bus.AWVALID = 1'b0;
  endtask

  task automatic arHandshake(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [LEN_W-1:0] len, input logic [1:0] burst);
    int cnt;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd2;
    bus.ARBURST = burst; bus.ARVALID = 1'b1;
    cnt = 0;
    @(negedge ACLK);
    while (!bus.ARREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
    if (!bus.ARREADY) checkOutput("arTimeout", 32'(bus.ARREADY), 32'd1);
    tick();
    bus.ARVALID = 1'b0;
  endtask

  task automatic sendWBeats(input int len, input logic [3:0] strb);
    int cnt;
    for (int i = 0; i <= len; i++) begin
      bus.WDATA = wBuf[i]; bus.WSTRB = strb; bus.WLAST = (i == len); bus.WVALID = 1'b1;
      cnt = 0;
      @(negedge ACLK);
      while (!bus.WREADY && cnt < 100) begin @(negedge ACLK); cnt++; end
      if (!bus.WREADY) checkOutput("wTimeout", 32'(bus.WREADY), 32'd1);
      tick();
    end
    bus.WVALID = 1'b0;
    bus.WLAST = 1'b0;
  endtask

  task automatic collectRBeats(input int len, input int stallBeat);
    int cnt;
    for (int i = 0; i <= len; i++) begin
      cnt = 0;
      @(negedge ACLK);
      while (!bus.RVALID && cnt < 100) begin @(negedge ACLK); cnt++; end
      if (!bus.RVALID) checkOutput("rTimeout", 32'(bus.RVALID), 32'd1);
      if (i == stallBeat) begin
        repeat (5) begin
          @(negedge ACLK);
          checkOutput("stallValid", 32'(bus.RVALID), 32'd1);
          checkOutput("stallData", bus.RDATA, rBuf[i]);
          checkOutput("stallCs", 32'(bus.CS), 32'd0);
        end
      end
      tick();
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
    end
  endtask

  task automatic drainQueues();
    int cnt;
    cnt = 0;
    while ((rQueue.size() != 0 || bQueue.size() != 0) && cnt < 100) begin tick(); cnt++; end
    checkOutput("rDrain", 32'(rQueue.size()), 32'd0);
    checkOutput("bDrain", 32'(bQueue.size()), 32'd0);
  endtask

  task automatic writeBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [3:0] strb, input logic [1:0] resp);
    bQueue.push_back('{resp, id});
    awHandshake(id, addr, LEN_W'(len), burst);
    sendWBeats(len, strb);
    drainQueues();
  endtask

  task automatic readBurst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [1:0] resp, input int stallBeat);
    for (int i = 0; i <= len; i++) rQueue.push_back('{rBuf[i], resp, (i == len), id});
    arHandshake(id, addr, LEN_W'(len), burst);
    collectRBeats(len, stallBeat);
    drainQueues();
  endtask

  task automatic applyStimulus();
    int start;
    int writesBefore;
    int cnt;
    logic gotWrite;
    logic [31:0] arbData;
    logic expGrant [3];
    logic [ADDR_W-1:0] expWrap [4];

    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    bus.RREADY = 1'b0; bus.BREADY = 1'b1; bus.WDATA = '0; bus.WSTRB = '0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    #12;
    checkResetOutputs();
    repeat (2) tick();
    ARESETn = 1'b1;
    repeat (2) tick();

    // INCR write then readback of the same four words.
    wBuf[0] = 32'h11; wBuf[1] = 32'h22; wBuf[2] = 32'h33; wBuf[3] = 32'h44;
    writeBurst(8'h12, 32'h100, 3, 2'b01, 4'hF, 2'b00);
    rBuf[0] = 32'h11; rBuf[1] = 32'h22; rBuf[2] = 32'h33; rBuf[3] = 32'h44;
    readBurst(8'h13, 32'h100, 3, 2'b01, 2'b00, -1);

    // WRAP read starting mid-window wraps at the 16-byte boundary.
    start = readLog.size();
    rBuf[0] = 32'h33; rBuf[1] = 32'h44; rBuf[2] = 32'h11; rBuf[3] = 32'h22;
    readBurst(8'h14, 32'h108, 3, 2'b10, 2'b00, -1);
    expWrap[0] = 14'h42; expWrap[1] = 14'h43; expWrap[2] = 14'h40; expWrap[3] = 14'h41;
    checkOutput("wrapCount", 32'(readLog.size() - start), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (start + i < readLog.size()) checkOutput("wrapAddr", 32'(readLog[start+i]), 32'(expWrap[i]));
    end

    // Byte-strobed single write over a zero word.
    wBuf[0] = 32'hAABBCCDD;
    writeBurst(8'h15, 32'h0, 0, 2'b01, 4'b0101, 2'b00);
    rBuf[0] = 32'h00BB00DD;
    readBurst(8'h16, 32'h0, 0, 2'b01, 2'b00, -1);

    // Back-pressure on beat 1.
    rBuf[0] = 32'h11; rBuf[1] = 32'h22;
    readBurst(8'h17, 32'h100, 1, 2'b01, 2'b00, 1);

    // Reserved burst type: beats complete with zero data and SLVERR.
    rBuf[0] = 32'h0; rBuf[1] = 32'h0;
    readBurst(8'h18, 32'h100, 1, 2'b11, 2'b10, -1);

    // Simultaneous requests, three rounds.
`ifdef AXI_SRAM_RR_ARB_EN
    expGrant[0] = 1'b1; expGrant[1] = 1'b0; expGrant[2] = 1'b1;
`else
    expGrant[0] = 1'b1; expGrant[1] = 1'b1; expGrant[2] = 1'b1;
`endif
    arbData = 32'h0;
    for (int k = 0; k < 3; k++) begin
      bus.AWID = ID_W'(8'h60 + k); bus.AWADDR = 32'h200; bus.AWLEN = '0; bus.AWSIZE = 3'd2;
      bus.AWBURST = 2'b01; bus.ARID = ID_W'(8'h70 + k); bus.ARADDR = 32'h200; bus.ARLEN = '0;
      bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
      cnt = 0;
      @(negedge ACLK);
      while (!(bus.AWREADY || bus.ARREADY) && cnt < 100) begin @(negedge ACLK); cnt++; end
      gotWrite = bus.AWREADY;
      checkOutput("arbGrant", 32'(gotWrite), 32'(expGrant[k]));
      tick();
      bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
      if (gotWrite) begin
        bQueue.push_back('{2'b00, ID_W'(8'h60 + k)});
        wBuf[0] = 32'hA0 + 32'(k);
        sendWBeats(0, 4'hF);
        arbData = 32'hA0 + 32'(k);
      end else begin
        rBuf[0] = arbData;
        rQueue.push_back('{arbData, 2'b00, 1'b1, ID_W'(8'h70 + k)});
        collectRBeats(0, -1);
      end
      drainQueues();
    end

    // Reset asserted mid write burst with WVALID still high.
    for (int i = 0; i < 4; i++) wBuf[i] = 32'h5500 + 32'(i);
    awHandshake(8'h90, 32'h300, 4'd3, 2'b01);
    sendWBeats(1, 4'hF);
    bus.WDATA = wBuf[2]; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
    writesBefore = writeCount;
    ARESETn = 1'b0;
    #1;
    checkResetOutputs();
    repeat (3) tick();
    ARESETn = 1'b1;
    repeat (3) tick();
    checkOutput("noWriteAfterReset", 32'(writeCount), 32'(writesBefore));
    checkOutput("abortedBeat", mem[14'hC2], 32'd0);
    bus.WVALID = 1'b0;
    rBuf[0] = 32'h5500; rBuf[1] = 32'h5501;
    readBurst(8'h91, 32'h300, 1, 2'b01, 2'b00, -1);
  endtask

  initial begin : mainFlow
    applyStimulus();
    checkOutput("finalR", 32'(rQueue.size()), 32'd0);
    checkOutput("finalB", 32'(bQueue.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
